// File: rtl/aes_seq_pkg.sv
// Shared types for the AES sequencer: FSM state encoding and the host-visible
// operation/chaining mode encodings, matching the round control unit.
package aes_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_BUSY,
    ST_DONE,
    ST_HALT
  } seq_state_t;

  typedef enum logic [1:0] {
    ENCRYPTION     = 2'd0,
    KEY_DERIVATION = 2'd1,
    DECRYPTION     = 2'd2,
    DECRYP_W_DERIV = 2'd3
  } op_mode_t;

  typedef enum logic [1:0] {
    ECB = 2'd0,
    CBC = 2'd1,
    CTR = 2'd2
  } aes_mode_t;

endpackage

// File: rtl/aes_word_cnt.sv
// 2-bit wrapping word counter for the four 32-bit words of a 128-bit block.
// clr has priority over inc; last flags the final word index.
module aes_word_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [1:0] cnt,
  output logic       last
);

  // Count words; wrap from 3 back to 0 naturally.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 2'd1;
    end
  end

  assign last = (cnt == 2'd3);

endmodule

// File: rtl/aes_seq_ctrl.sv
// AES host sequencer: walks IDLE -> LOAD -> START -> BUSY -> DONE (or HALT for
// key derivation), tracks data word indices, and keeps sticky status flags.
// Optional DMA request outputs are enabled by defining AES_SEQ_DMA_EN.
module aes_seq_ctrl
  import aes_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] cfg_op_mode,
  input  logic [1:0] cfg_aes_mode,
  input  logic       din_wr,
  input  logic       dout_rd,
  input  logic       ccf_clr,
  input  logic       err_clr,
  input  logic       ccfie,
  input  logic       errie,
  input  logic       end_comp,
  output logic       start,
  output logic       disable_core,
  output logic [1:0] operation_mode,
  output logic [1:0] aes_mode,
  output logic [1:0] din_sel,
  output logic [1:0] dout_sel,
  output logic       busy,
  output logic       ccf,
  output logic       wrerr,
  output logic       rderr,
`ifdef AES_SEQ_DMA_EN
  input  logic       dma_in_en,
  input  logic       dma_out_en,
  output logic       dma_req_in,
  output logic       dma_req_out,
`endif
  output logic       irq
);

  seq_state_t state_q;
  seq_state_t state_d;
  logic       din_inc;
  logic       dout_inc;
  logic       din_last;
  logic       dout_last;
  logic       cnt_clr;
  logic       ccf_set;
  logic       wrerr_set;
  logic       rderr_set;

  // Next-state and counter-enable decode; en=0 overrides every state.
  always_comb begin
    state_d  = state_q;
    din_inc  = 1'b0;
    dout_inc = 1'b0;
    cnt_clr  = !en;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = (cfg_op_mode == KEY_DERIVATION) ? ST_START : ST_LOAD;
        ST_LOAD: begin
          if (din_wr) begin
            din_inc = 1'b1;
            if (din_last) state_d = ST_START;
          end
        end
        ST_START: state_d = ST_BUSY;
        ST_BUSY: begin
          if (end_comp)
            state_d = (operation_mode == KEY_DERIVATION) ? ST_HALT : ST_DONE;
        end
        ST_DONE: begin
          if (dout_rd) begin
            dout_inc = 1'b1;
            if (dout_last) state_d = ST_LOAD;
          end
        end
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State register with start/busy registered from the next state so they
  // line up exactly with the START and BUSY states; modes latch on leaving IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      start          <= 1'b0;
      busy           <= 1'b0;
      operation_mode <= ENCRYPTION;
      aes_mode       <= ECB;
    end else begin
      state_q <= state_d;
      start   <= (state_d == ST_START);
      busy    <= (state_d == ST_START) || (state_d == ST_BUSY);
      if (state_q == ST_IDLE && en) begin
        operation_mode <= cfg_op_mode;
        aes_mode       <= cfg_aes_mode;
      end
    end
  end

  assign ccf_set   = (state_q == ST_BUSY) && end_comp && en;
  assign wrerr_set = din_wr && (state_q != ST_LOAD);
  assign rderr_set = dout_rd && (state_q != ST_DONE);

  // Sticky status flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ccf   <= 1'b0;
      wrerr <= 1'b0;
      rderr <= 1'b0;
    end else begin
      ccf   <= ccf_set   | (ccf   & ~ccf_clr);
      wrerr <= wrerr_set | (wrerr & ~err_clr);
      rderr <= rderr_set | (rderr & ~err_clr);
    end
  end

  // Core disable follows the inverted enable one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      disable_core <= 1'b1;
    end else begin
      disable_core <= !en;
    end
  end

  assign irq = (ccf & ccfie) | ((wrerr | rderr) & errie);

`ifdef AES_SEQ_DMA_EN
  assign dma_req_in  = (state_q == ST_LOAD) && dma_in_en;
  assign dma_req_out = (state_q == ST_DONE) && dma_out_en;
`endif

  aes_word_cnt u_din_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (din_inc),
    .cnt  (din_sel),
    .last (din_last)
  );

  aes_word_cnt u_dout_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (dout_inc),
    .cnt  (dout_sel),
    .last (dout_last)
  );

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Scoreboard bench for aes_seq_ctrl: expected values are queued as stimulus
// is driven and compared after the following clock edge (or settle delay).
module tb_aes_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] cfg_op_mode;
  logic [1:0] cfg_aes_mode;
  logic       din_wr;
  logic       dout_rd;
  logic       ccf_clr;
  logic       err_clr;
  logic       ccfie;
  logic       errie;
  logic       end_comp;
  logic       start;
  logic       disable_core;
  logic [1:0] operation_mode;
  logic [1:0] aes_mode;
  logic [1:0] din_sel;
  logic [1:0] dout_sel;
  logic       busy;
  logic       ccf;
  logic       wrerr;
  logic       rderr;
  logic       irq;
`ifdef AES_SEQ_DMA_EN
  logic       dma_in_en;
  logic       dma_out_en;
  logic       dma_req_in;
  logic       dma_req_out;
`endif

  int unsigned n_vec;
  int unsigned n_err;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  aes_seq_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .cfg_op_mode    (cfg_op_mode),
    .cfg_aes_mode   (cfg_aes_mode),
    .din_wr         (din_wr),
    .dout_rd        (dout_rd),
    .ccf_clr        (ccf_clr),
    .err_clr        (err_clr),
    .ccfie          (ccfie),
    .errie          (errie),
    .end_comp       (end_comp),
    .start          (start),
    .disable_core   (disable_core),
    .operation_mode (operation_mode),
    .aes_mode       (aes_mode),
    .din_sel        (din_sel),
    .dout_sel       (dout_sel),
    .busy           (busy),
    .ccf            (ccf),
    .wrerr          (wrerr),
    .rderr          (rderr),
`ifdef AES_SEQ_DMA_EN
    .dma_in_en      (dma_in_en),
    .dma_out_en     (dma_out_en),
    .dma_req_in     (dma_req_in),
    .dma_req_out    (dma_req_out),
`endif
    .irq            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input string tag);
    case (tag)
      "start":    return {31'd0, start};
      "busy":     return {31'd0, busy};
      "dis":      return {31'd0, disable_core};
      "op":       return {30'd0, operation_mode};
      "aes":      return {30'd0, aes_mode};
      "din_sel":  return {30'd0, din_sel};
      "dout_sel": return {30'd0, dout_sel};
      "ccf":      return {31'd0, ccf};
      "wrerr":    return {31'd0, wrerr};
      "rderr":    return {31'd0, rderr};
      "irq":      return {31'd0, irq};
`ifdef AES_SEQ_DMA_EN
      "dma_in":   return {31'd0, dma_req_in};
      "dma_out":  return {31'd0, dma_req_out};
`endif
      default:    return 'x;
    endcase
  endfunction

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, observe(e.tag), e.val);
    end
  endtask

  // Advance one clock edge, then compare everything queued.
  task automatic cycle();
    @(posedge clk);
    #1;
    sb_drain();
  endtask

  // Compare combinational outputs without a clock edge.
  task automatic settle();
    #1;
    sb_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b1;
    cfg_op_mode = 2'd2; cfg_aes_mode = 2'd2;
    din_wr = 0; dout_rd = 0; ccf_clr = 0; err_clr = 0;
    ccfie = 0; errie = 0; end_comp = 0;
`ifdef AES_SEQ_DMA_EN
    dma_in_en = 1'b1; dma_out_en = 1'b1;
`endif
    @(posedge clk); #1;

    // Reset values, with rst dominating en=1
    sb_push("busy", 0); sb_push("start", 0); sb_push("din_sel", 0);
    sb_push("dout_sel", 0); sb_push("op", 0); sb_push("aes", 0);
    sb_push("ccf", 0); sb_push("wrerr", 0); sb_push("rderr", 0);
    sb_push("dis", 1); sb_push("irq", 0);
    cycle();
    rst = 1'b0; en = 1'b0;
    cycle();

    // Encryption / ECB full block
    cfg_op_mode = 2'd0; cfg_aes_mode = 2'd0; en = 1'b1;
    sb_push("dis", 0); sb_push("busy", 0); sb_push("op", 0); sb_push("din_sel", 0);
`ifdef AES_SEQ_DMA_EN
    sb_push("dma_in", 1);
`endif
    cycle();
    for (int i = 0; i < 4; i++) begin
      din_wr = 1'b1;
      if (i == 1) cfg_op_mode = 2'd2;
      sb_push("din_sel", (i + 1) % 4);
      sb_push("start", (i == 3) ? 1 : 0);
      sb_push("busy", (i == 3) ? 1 : 0);
      sb_push("wrerr", 0);
`ifdef AES_SEQ_DMA_EN
      sb_push("dma_in", (i == 3) ? 0 : 1);
`endif
      cycle();
      din_wr = 1'b0;
    end
    sb_push("start", 0); sb_push("busy", 1); sb_push("op", 0); sb_push("ccf", 0);
`ifdef AES_SEQ_DMA_EN
    sb_push("dma_out", 0);
`endif
    cycle();
    cfg_op_mode = 2'd0;
    end_comp = 1'b1;
    sb_push("ccf", 1); sb_push("busy", 0); sb_push("dout_sel", 0);
`ifdef AES_SEQ_DMA_EN
    sb_push("dma_out", 1);
`endif
    cycle();
    end_comp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dout_rd = 1'b1;
      sb_push("dout_sel", (i + 1) % 4);
      sb_push("rderr", 0);
`ifdef AES_SEQ_DMA_EN
      sb_push("dma_out", (i == 3) ? 0 : 1);
`endif
      cycle();
      dout_rd = 1'b0;
    end
    // Now in LOAD: a read is an error and leaves dout_sel alone
    dout_rd = 1'b1;
    sb_push("rderr", 1); sb_push("dout_sel", 0);
`ifdef AES_SEQ_DMA_EN
    sb_push("dma_in", 1);
`endif
    cycle();
    dout_rd = 1'b0;
    errie = 1'b1;
    sb_push("irq", 1);
    settle();
    err_clr = 1'b1;
    sb_push("rderr", 0); sb_push("irq", 0);
    cycle();
    err_clr = 1'b0;
    ccfie = 1'b1;
    sb_push("irq", 1);
    settle();
    ccf_clr = 1'b1;
    sb_push("ccf", 0); sb_push("irq", 0);
    cycle();
    ccf_clr = 1'b0;
    din_wr = 1'b1;
    sb_push("din_sel", 1); sb_push("wrerr", 0);
    cycle();
    din_wr = 1'b0;
    en = 1'b0;
    sb_push("din_sel", 0); sb_push("dis", 1); sb_push("busy", 0);
    cycle();

    // Key derivation: straight to START, then HALT until en drops
    cfg_op_mode = 2'd1; en = 1'b1;
    sb_push("start", 1); sb_push("busy", 1); sb_push("op", 1); sb_push("dis", 0);
    cycle();
    sb_push("start", 0); sb_push("busy", 1);
    cycle();
    end_comp = 1'b1;
    sb_push("ccf", 1); sb_push("busy", 0);
    cycle();
    end_comp = 1'b0;
    sb_push("busy", 0); sb_push("start", 0); sb_push("ccf", 1);
    cycle();
    dout_rd = 1'b1;
    sb_push("rderr", 1); sb_push("dout_sel", 0);
    cycle();
    dout_rd = 1'b0;
    en = 1'b0;
    sb_push("dis", 1);
    cycle();
    ccf_clr = 1'b1; err_clr = 1'b1;
    sb_push("ccf", 0); sb_push("rderr", 0);
    cycle();
    ccf_clr = 1'b0; err_clr = 1'b0;

    // Write error during BUSY, then set/clear collision on ccf
    cfg_op_mode = 2'd0; en = 1'b1;
    sb_push("busy", 0); sb_push("op", 0); sb_push("din_sel", 0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      din_wr = 1'b1;
      sb_push("start", (i == 3) ? 1 : 0);
      cycle();
      din_wr = 1'b0;
    end
    sb_push("busy", 1);
    cycle();
    din_wr = 1'b1;
    sb_push("wrerr", 1); sb_push("din_sel", 0);
    cycle();
    din_wr = 1'b0;
    sb_push("irq", 1);
    settle();
    err_clr = 1'b1;
    sb_push("wrerr", 0); sb_push("irq", 0);
    cycle();
    err_clr = 1'b0;
    ccf_clr = 1'b1; end_comp = 1'b1;
    sb_push("ccf", 1); sb_push("irq", 1); sb_push("busy", 0);
    cycle();
    end_comp = 1'b0;
    sb_push("ccf", 0);
    cycle();
    ccf_clr = 1'b0;
    end_comp = 1'b1;
    sb_push("ccf", 0);
    cycle();
    end_comp = 1'b0;

    // Abort mid-read, then mid-load, then re-enable with CBC
    for (int i = 0; i < 2; i++) begin
      dout_rd = 1'b1;
      sb_push("dout_sel", i + 1);
      cycle();
      dout_rd = 1'b0;
    end
    en = 1'b0;
    sb_push("dout_sel", 0);
    cycle();
    en = 1'b1;
    cycle();
    for (int i = 0; i < 2; i++) begin
      din_wr = 1'b1;
      sb_push("din_sel", i + 1);
      cycle();
      din_wr = 1'b0;
    end
    en = 1'b0;
    sb_push("din_sel", 0);
    cycle();
    cfg_aes_mode = 2'd1; en = 1'b1;
    sb_push("aes", 1);
    cycle();
    cfg_aes_mode = 2'd2;
    for (int i = 0; i < 4; i++) begin
      din_wr = 1'b1;
      sb_push("din_sel", (i + 1) % 4);
      sb_push("start", (i == 3) ? 1 : 0);
      cycle();
      din_wr = 1'b0;
    end
    sb_push("busy", 1); sb_push("aes", 1);
    cycle();

    // end_comp in the same cycle en drops is ignored
    en = 1'b0; end_comp = 1'b1;
    sb_push("ccf", 0); sb_push("busy", 0);
    cycle();
    end_comp = 1'b0;
    en = 1'b1;
    sb_push("busy", 0); sb_push("aes", 2); sb_push("ccf", 0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
